// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg
// Shared definitions for the EX-stage multiply/divide unit: ALU control
// opcodes consumed by hilo_muldiv, the divider state encoding (exported so
// hazard and trace logic can decode it) and a small absolute-value helper.
package hilo_muldiv_pkg;

    // EX-stage ALU control codes
    localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    // Divider state encoding
    localparam logic [1:0] DIV_ST_IDLE = 2'd0;
    localparam logic [1:0] DIV_ST_RUN  = 2'd1;
    localparam logic [1:0] DIV_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = DIV_ST_IDLE,
        ST_RUN  = DIV_ST_RUN,
        ST_DONE = DIV_ST_DONE
    } div_state_e;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude for the divider datapath.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/hilo_muldiv_div_radix2.sv
// div_radix2
// Iterative restoring radix-2 divider, one quotient bit per cycle.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           begin a divide (only honoured in IDLE)
//   signed_i        treat a_i/b_i as two's-complement (DIV vs DIVU)
//   a_i, b_i        dividend / divisor, sampled on start
//   abort           drop any divide in progress and return to IDLE
//   busy            high while in RUN
//   done            high for the single DONE cycle
//   quotient        sign-corrected quotient (valid while done)
//   remainder       sign-corrected remainder (valid while done)
module div_radix2
    import hilo_muldiv_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam logic [4:0] LAST_STEP = 5'(DIV_CYCLES - 1);

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [31:0] dq_q, dq_d;
    logic [31:0] dvs_q, dvs_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;

    // 33-bit partial remainder after bringing in the next dividend bit.
    logic [32:0] rem_shift;
    logic        fits;
    logic        b_zero;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dq_d      = dq_q;
        dvs_d     = dvs_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        rem_shift = {rem_q, dq_q[31]};
        fits      = (rem_shift >= {1'b0, dvs_q});
        b_zero    = (b_i == 32'd0);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = 5'd0;
                    rem_d   = 32'd0;
                    // A zero divisor keeps the raw dividend so the natural
                    // all-ones quotient / dividend remainder falls out uncorrected.
                    dq_d    = (signed_i && !b_zero) ? abs32(a_i) : a_i;
                    dvs_d   = signed_i ? abs32(b_i) : b_i;
                    qneg_d  = signed_i && !b_zero && (a_i[31] ^ b_i[31]);
                    rneg_d  = signed_i && !b_zero && a_i[31];
                end
            end
            ST_RUN: begin
                rem_d = fits ? (rem_shift[31:0] - dvs_q) : rem_shift[31:0];
                dq_d  = {dq_q[30:0], fits};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            rem_q   <= 32'd0;
            dq_q    <= 32'd0;
            dvs_q   <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign quotient  = qneg_q ? (32'd0 - dq_q) : dq_q;
    assign remainder = rneg_q ? (32'd0 - rem_q) : rem_q;

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv
// EX-stage multiply/divide unit with the HI/LO register pair. Multiplies and
// MTHI/MTLO write in one cycle; divides use div_radix2 and stall the pipe.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   alucontrol   EX-stage ALU control code
//   a, b         rs / rt operand values
//   valid_i      EX instruction is real (not a bubble)
//   flush_i      kill the EX instruction and any divide in progress
//   stall_o      hold IF..EX while a divide is being accepted or running
//   result_o     HI for MFHI, LO for MFLO, otherwise 0
//   hi_o, lo_o   current HI / LO registers
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  alucontrol,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        valid_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic [31:0] result_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        div_busy, div_done;
    logic [31:0] div_quot, div_rem;
    logic        acc, is_div, div_start;
    logic [63:0] prod_s, prod_u;

    assign acc       = valid_i & ~flush_i & ~div_busy & ~div_done;
    assign is_div    = (alucontrol == EXE_DIV_OP) || (alucontrol == EXE_DIVU_OP);
    assign div_start = acc & is_div;

    // Operands are extended explicitly so both products are full 64-bit.
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    div_radix2 #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .signed_i  (alucontrol == EXE_DIV_OP),
        .a_i       (a),
        .b_i       (b),
        .abort     (flush_i),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    // HI/LO write arbitration; flush suppresses every write source.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (div_done && !flush_i) begin
            hi_d = div_rem;
            lo_d = div_quot;
        end else if (acc) begin
            case (alucontrol)
                EXE_MULT_OP:  {hi_d, lo_d} = prod_s;
                EXE_MULTU_OP: {hi_d, lo_d} = prod_u;
                EXE_MTHI_OP:  hi_d = a;
                EXE_MTLO_OP:  lo_d = a;
                default: begin
                    hi_d = hi_q;
                    lo_d = lo_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // The accept cycle stalls too, so the divide holds EX until DONE.
    assign stall_o = div_start | (div_busy & ~flush_i);

    always_comb begin
        result_o = 32'd0;
        if (alucontrol == EXE_MFHI_OP) begin
            result_o = hi_q;
        end else if (alucontrol == EXE_MFLO_OP) begin
            result_o = lo_q;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule
